// File: rtl/output_serializer.sv
// Captures NUM_CORES words per start pulse into a FIFO and streams them out with m_tlast per group.
// Optional OUT_SERIALIZER_RELU_EN clamps negative signed elements to zero before the FIFO write.
module output_serializer #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH*CHUNK_SIZE-1:0] in_data,
    output logic [WIDTH*CHUNK_SIZE-1:0] m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic                        busy,
    output logic                        overflow
);
    localparam int DW    = WIDTH * CHUNK_SIZE;
    localparam int IDX_W = $clog2(NUM_CORES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DW-1:0]         wr_word;
    logic                  push_req;
    logic                  pop;
    logic                  accept;

`ifdef OUT_SERIALIZER_RELU_EN
    always_comb begin
        wr_word = in_data;
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            if (in_data[(i+1)*WIDTH-1]) begin
                wr_word[i*WIDTH +: WIDTH] = '0;
            end
        end
    end
`else
    assign wr_word = in_data;
`endif

    assign push_req = (state == CAPTURE);
    assign pop      = m_tvalid && m_tready;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign accept   = push_req && ((count < DEPTH_CNT) || pop);

    assign m_tvalid = (count != '0);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    assign m_tlast  = m_tvalid ? tag_mem[rd_ptr] : 1'b0;
    assign busy     = (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CAPTURE;
                        idx   <= '0;
                    end
                end
                CAPTURE: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                    if (!accept) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                mem[wr_ptr]     <= wr_word;
                tag_mem[wr_ptr] <= (idx == LAST_IDX);
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: directed scenarios plus random traffic against a queue model.
module tb_output_serializer;
    localparam int WIDTH      = 16;
    localparam int CHUNK_SIZE = 4;
    localparam int NUM_CORES  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DW         = WIDTH * CHUNK_SIZE;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] in_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          overflow;

    output_serializer #(
        .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES(NUM_CORES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of stored words and how many group words are still to be captured.
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    int            cap_left = 0;
    logic          m_ovf = 1'b0;

    int busy_cnt, pops, lasts;

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic signed [WIDTH-1:0] e;
        r = d;
`ifdef OUT_SERIALIZER_RELU_EN
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            e = d[i*WIDTH +: WIDTH];
            if (e < 0) r[i*WIDTH +: WIDTH] = '0;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic [DW-1:0] d, input logic r, input logic rn);
        bit do_pop, accepted;
        if (!rn) begin
            q_data.delete();
            q_last.delete();
            cap_left = 0;
            m_ovf    = 1'b0;
        end else begin
            do_pop   = (q_data.size() != 0) && r;
            accepted = (q_data.size() < FIFO_DEPTH) || do_pop;
            if (do_pop) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (cap_left > 0) begin
                if (accepted) begin
                    q_data.push_back(relu_ref(d));
                    q_last.push_back(cap_left == 1);
                end else begin
                    m_ovf = 1'b1;
                end
                cap_left--;
            end else if (s) begin
                cap_left = NUM_CORES;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare on the following falling edge.
    task automatic applyStimulus(input logic s, input logic [DW-1:0] d, input logic r, input logic rn);
        if (rn && m_tvalid && r) begin
            pops++;
            if (m_tlast) lasts++;
        end
        start    = s;
        in_data  = d;
        m_tready = r;
        rst_n    = rn;
        model_step(s, d, r, rn);
        @(posedge clk);
        @(negedge clk);
        if (busy) busy_cnt++;
        checkOutput("valid", DW'(m_tvalid), DW'(q_data.size() != 0));
        if (q_data.size() != 0) begin
            checkOutput("data", m_tdata, q_data[0]);
            checkOutput("last", DW'(m_tlast), DW'(q_last[0]));
        end
        if (!rn) begin
            checkOutput("rst_data", m_tdata, '0);
            checkOutput("rst_last", DW'(m_tlast), '0);
        end
        checkOutput("busy", DW'(busy), DW'(cap_left > 0));
        checkOutput("overflow", DW'(overflow), DW'(m_ovf));
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        pops     = 0;
        lasts    = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_group(input logic r, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        logic [DW-1:0] w;
        w = base;
        applyStimulus(1'b1, '0, r, 1'b1);
        for (int i = 0; i < NUM_CORES; i++) begin
            applyStimulus(1'b0, w, r, 1'b1);
            w = w + inc;
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, DW'({$urandom, $urandom}), r, 1'b1);
    endtask

    localparam logic [DW-1:0] BASE = 64'h0001_0002_0003_0004;
    localparam logic [DW-1:0] INC  = 64'h0004_0004_0004_0004;

    initial begin
        logic [WIDTH-1:0] relu_exp0;
        logic [DW-1:0]    w;
        logic             ready_mode;
        logic             r;

        start = 1'b0; in_data = '0; m_tready = 1'b0; rst_n = 1'b0;
        do_reset();
        checkOutput("reset_valid", DW'(m_tvalid), '0);
        checkOutput("reset_busy", DW'(busy), '0);

        // Basic group
        clear_counts();
        send_group(1'b1, BASE, INC);
        idle(4, 1'b1);
        checkOutput("basic_busy_cycles", DW'(busy_cnt), DW'(4));
        checkOutput("basic_words", DW'(pops), DW'(4));
        checkOutput("basic_lasts", DW'(lasts), DW'(1));

        // Backpressure: four groups into an 8-deep FIFO while stalled
        clear_counts();
        w = BASE;
        for (int g = 0; g < 4; g++) begin
            send_group(1'b0, w, INC);
            w = w + INC * NUM_CORES;
        end
        checkOutput("bp_overflow", DW'(overflow), DW'(1));
        idle(12, 1'b1);
        checkOutput("bp_words", DW'(pops), DW'(8));
        checkOutput("bp_lasts", DW'(lasts), DW'(2));
        checkOutput("bp_overflow_sticky", DW'(overflow), DW'(1));
        do_reset();
        checkOutput("bp_overflow_cleared", DW'(overflow), '0);

        // Full FIFO with a pop on every capture edge
        clear_counts();
        send_group(1'b0, 64'h1000, 64'h1);
        send_group(1'b0, 64'h2000, 64'h1);
        applyStimulus(1'b1, '0, 1'b0, 1'b1);
        w = 64'h3000;
        for (int i = 0; i < NUM_CORES; i++) begin
            applyStimulus(1'b0, w, 1'b1, 1'b1);
            w = w + 1;
        end
        checkOutput("full_pop_overflow", DW'(overflow), '0);
        idle(10, 1'b1);
        checkOutput("full_pop_words", DW'(pops), DW'(12));

        // Start pulse during capture is ignored
        clear_counts();
        applyStimulus(1'b1, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 64'hA0, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'hA1, 1'b1, 1'b1);
        applyStimulus(1'b0, 64'hA2, 1'b1, 1'b1);
        applyStimulus(1'b0, 64'hA3, 1'b1, 1'b1);
        idle(6, 1'b1);
        checkOutput("restart_words", DW'(pops), DW'(4));
        checkOutput("restart_busy_cycles", DW'(busy_cnt), DW'(4));

        // Reset in the middle of a capture
        applyStimulus(1'b1, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'hB0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'hB1, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'hB2, 1'b0, 1'b0);
        checkOutput("midrst_valid", DW'(m_tvalid), '0);
        clear_counts();
        idle(3, 1'b1);
        checkOutput("midrst_no_stale", DW'(pops), '0);
        send_group(1'b1, 64'hC0, 64'h1);
        idle(4, 1'b1);
        checkOutput("midrst_words", DW'(pops), DW'(4));
        checkOutput("midrst_overflow", DW'(overflow), '0);

        // ReLU behaviour on a negative and a positive element
`ifdef OUT_SERIALIZER_RELU_EN
        relu_exp0 = 16'h0000;
`else
        relu_exp0 = 16'hFF80;
`endif
        applyStimulus(1'b1, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'h0001_0002_0180_FF80, 1'b0, 1'b1);
        checkOutput("relu_neg", DW'(m_tdata[15:0]), DW'(relu_exp0));
        checkOutput("relu_pos", DW'(m_tdata[31:16]), DW'(16'h0180));
        for (int i = 1; i < NUM_CORES; i++) applyStimulus(1'b0, 64'h8000_7FFF_FFFF_0001, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Random traffic
        ready_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) ready_mode = ~ready_mode;
            r = ready_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 5) == 0, DW'({$urandom, $urandom}), r,
                          $urandom_range(0, 299) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
